// File: rtl/rv32imf_clock_gate_ctrl_if.sv
// ---------------------------------------------------------------------------
// rv32imf_clock_gate_ctrl_if
//
// Bundles the sleep/wake control signals between the requesting units and
// the clock-gate sequencer.
//
//   sleep_en_i  : software permission to gate (e.g. WFI executed)
//   force_en_i  : debug/scan override that keeps the clock running
//   busy_i      : per-unit busy level
//   wake_i      : per-unit wake request level
//   cg_en_o     : enable to the clock gate cell (registered)
//   sleeping_o  : high while gated or waking (registered)
//   wake_ack_o  : one-cycle acknowledge pulse per waker (registered)
//
// master : the requester/system side (drives the *_i signals)
// slave  : the sequencer side (drives the *_o signals)
// ---------------------------------------------------------------------------
interface rv32imf_clock_gate_ctrl_if #(
    parameter int NUM_REQ = 4
);
    logic               sleep_en_i;
    logic               force_en_i;
    logic [NUM_REQ-1:0] busy_i;
    logic [NUM_REQ-1:0] wake_i;
    logic               cg_en_o;
    logic               sleeping_o;
    logic [NUM_REQ-1:0] wake_ack_o;

    modport master (
        output sleep_en_i,
        output force_en_i,
        output busy_i,
        output wake_i,
        input  cg_en_o,
        input  sleeping_o,
        input  wake_ack_o
    );

    modport slave (
        input  sleep_en_i,
        input  force_en_i,
        input  busy_i,
        input  wake_i,
        output cg_en_o,
        output sleeping_o,
        output wake_ack_o
    );
endinterface

// File: rtl/rv32imf_clock_gate_ctrl.sv
// ---------------------------------------------------------------------------
// rv32imf_clock_gate_ctrl
//
// Sleep/wake sequencer for the core-level clock gate. Runs on the free
// running clock. After the idle condition has held for IDLE_CYCLES it closes
// the gated clock; any wake request, the force override or loss of sleep
// permission reopens it, and after WAKE_CYCLES of running clock the units
// that are still requesting wake get a one-cycle acknowledge.
//
// Ports:
//   clk_i   : free-running (ungated) clock
//   rst_ni  : asynchronous active-low reset; reopens the clock immediately
//   cg_if   : slave side of rv32imf_clock_gate_ctrl_if (sleep_en_i,
//             force_en_i, busy_i, wake_i in; cg_en_o, sleeping_o,
//             wake_ack_o out)
//
// Parameters:
//   NUM_REQ     : number of requester units (1..16)
//   IDLE_CYCLES : consecutive idle cycles before gating (1..255)
//   WAKE_CYCLES : running cycles after re-enable before ack (1..15)
// ---------------------------------------------------------------------------
module rv32imf_clock_gate_ctrl #(
    parameter int NUM_REQ     = 4,
    parameter int IDLE_CYCLES = 8,
    parameter int WAKE_CYCLES = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    rv32imf_clock_gate_ctrl_if.slave cg_if
);

    localparam int IW = $clog2(IDLE_CYCLES + 1);
    localparam int WW = $clog2(WAKE_CYCLES + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
    localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_IDLE_WAIT = 2'd1,
        ST_GATED     = 2'd2,
        ST_WAKING    = 2'd3
    } state_e;

    state_e             state_q,    state_d;
    logic [IW-1:0]      idle_cnt_q, idle_cnt_d;
    logic [WW-1:0]      wake_cnt_q, wake_cnt_d;
    // Wakers captured on the WAKING->RUN edge; presented on the ack output
    // one edge later together with the falling sleeping_o.
    logic [NUM_REQ-1:0] ack_pend_q, ack_pend_d;
    logic               cg_en_q,    cg_en_d;
    logic               sleeping_q, sleeping_d;
    logic [NUM_REQ-1:0] wake_ack_q, wake_ack_d;

    logic wake_any;
    logic idle_cond;

    assign wake_any  = |cg_if.wake_i;
    assign idle_cond = cg_if.sleep_en_i & ~cg_if.force_en_i &
                       ~(|cg_if.busy_i) & ~wake_any;

    // ------------------------------------------------------------------
    // State register (all flops). Reset forces the clock back on at once.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_RUN;
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
            ack_pend_q <= '0;
            cg_en_q    <= 1'b1;
            sleeping_q <= 1'b0;
            wake_ack_q <= '0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;
            ack_pend_q <= ack_pend_d;
            cg_en_q    <= cg_en_d;
            sleeping_q <= sleeping_d;
            wake_ack_q <= wake_ack_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        wake_cnt_d = wake_cnt_q;
        ack_pend_d = '0;

        case (state_q)
            ST_RUN: begin
                idle_cnt_d = '0;
                if (idle_cond) begin
                    state_d = ST_IDLE_WAIT;
                end
            end

            ST_IDLE_WAIT: begin
                // Abort wins over the terminal count.
                if (!idle_cond) begin
                    state_d    = ST_RUN;
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_LAST) begin
                    state_d    = ST_GATED;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + IW'(1);
                end
            end

            ST_GATED: begin
                // busy_i is meaningless here: the units have no clock.
                if (wake_any || cg_if.force_en_i || !cg_if.sleep_en_i) begin
                    state_d    = ST_WAKING;
                    wake_cnt_d = '0;
                end
            end

            ST_WAKING: begin
                // Always runs to completion, whatever the inputs do.
                if (wake_cnt_q == WAKE_LAST) begin
                    state_d    = ST_RUN;
                    wake_cnt_d = '0;
                    ack_pend_d = cg_if.wake_i;
                end else begin
                    wake_cnt_d = wake_cnt_q + WW'(1);
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: decoded from the current state, then registered.
    // ------------------------------------------------------------------
    always_comb begin
        cg_en_d    = (state_q != ST_GATED);
        sleeping_d = (state_q == ST_GATED) || (state_q == ST_WAKING);
        wake_ack_d = ack_pend_q;
    end

    assign cg_if.cg_en_o    = cg_en_q;
    assign cg_if.sleeping_o = sleeping_q;
    assign cg_if.wake_ack_o = wake_ack_q;

endmodule

// File: tb/tb_rv32imf_clock_gate_ctrl.sv
module tb_rv32imf_clock_gate_ctrl;

    localparam int NR = 4;

    logic clk;
    logic rst_n;

    rv32imf_clock_gate_ctrl_if #(.NUM_REQ(NR)) cg_if ();

    rv32imf_clock_gate_ctrl #(
        .NUM_REQ    (NR),
        .IDLE_CYCLES(8),
        .WAKE_CYCLES(2)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .cg_if (cg_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output-change events: edge number at which the change shows,
    // and the output values after the change.
    typedef struct {
        int          cyc;
        logic        cg;
        logic        sl;
        logic [NR-1:0] ack;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    bit mon_en = 1'b0;
    logic [NR+1:0] prev_out;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Monitor: on every output change pop the next expected event.
    always @(negedge clk) begin
        logic [NR+1:0] cur;
        exp_t e;
        if (mon_en) begin
            cur = {cg_if.cg_en_o, cg_if.sleeping_o, cg_if.wake_ack_o};
            if (cur !== prev_out) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change edge=%0d got cg=%b sl=%b ack=%b",
                             edge_cnt, cur[NR+1], cur[NR], cur[NR-1:0]);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != edge_cnt || cur !== {e.cg, e.sl, e.ack}) begin
                        errors++;
                        $display("FAIL out_event got edge=%0d cg=%b sl=%b ack=%b, expected edge=%0d cg=%b sl=%b ack=%b",
                                 edge_cnt, cur[NR+1], cur[NR], cur[NR-1:0],
                                 e.cyc, e.cg, e.sl, e.ack);
                    end else begin
                        $display("event edge=%0d cg=%b sl=%b ack=%b ok",
                                 edge_cnt, cur[NR+1], cur[NR], cur[NR-1:0]);
                    end
                end
                prev_out = cur;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int cyc, input logic cg, input logic sl,
                        input logic [NR-1:0] ack);
        exp_t e;
        e.cyc = cyc; e.cg = cg; e.sl = sl; e.ack = ack;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [NR-1:0] got,
                       input logic [NR-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%b expected=%b", name, got, want);
        end else begin
            $display("check %s = %b ok", name, got);
        end
    endtask

    // Idle held from the next sampling edge: gate closes 9 edges later.
    task automatic go_gated();
        int s;
        cg_if.sleep_en_i = 1'b1;
        s = edge_cnt + 1;
        push(s + 9, 1'b0, 1'b1, '0);
        tick(12);
    endtask

    initial begin
        int s;
        rst_n            = 1'b1;
        cg_if.sleep_en_i = 1'b0;
        cg_if.force_en_i = 1'b0;
        cg_if.busy_i     = '0;
        cg_if.wake_i     = '0;
        #1 rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        chk("reset_cg_en",    {3'b000, cg_if.cg_en_o},    4'b0001);
        chk("reset_sleeping", {3'b000, cg_if.sleeping_o}, 4'b0000);
        chk("reset_wake_ack", cg_if.wake_ack_o,           4'b0000);
        prev_out = {1'b1, 1'b0, 4'b0000};
        mon_en   = 1'b1;

        // Basic gating
        go_gated();

        // Wake with two requesters
        cg_if.wake_i = 4'b0101;
        s = edge_cnt + 1;
        push(s + 1, 1'b1, 1'b1, 4'b0000);
        push(s + 3, 1'b1, 1'b0, 4'b0101);
        push(s + 4, 1'b1, 1'b0, 4'b0000);
        tick(5);
        cg_if.sleep_en_i = 1'b0;
        cg_if.wake_i     = '0;
        tick(2);

        // Idle abort on the 5th IDLE_WAIT cycle, then a full restart
        cg_if.sleep_en_i = 1'b1;
        tick(5);
        cg_if.busy_i = 4'b0100;
        tick(1);
        cg_if.busy_i = '0;
        s = edge_cnt + 1;
        push(s + 9, 1'b0, 1'b1, '0);
        tick(12);

        // Wake dropout: bit0 released during WAKING
        cg_if.wake_i = 4'b0011;
        s = edge_cnt + 1;
        push(s + 1, 1'b1, 1'b1, 4'b0000);
        push(s + 3, 1'b1, 1'b0, 4'b0010);
        push(s + 4, 1'b1, 1'b0, 4'b0000);
        tick(1);
        cg_if.wake_i = 4'b0010;
        tick(4);
        cg_if.sleep_en_i = 1'b0;
        cg_if.wake_i     = '0;
        tick(2);

        // Force while gated: exits through WAKING, no ack
        go_gated();
        cg_if.force_en_i = 1'b1;
        s = edge_cnt + 1;
        push(s + 1, 1'b1, 1'b1, 4'b0000);
        push(s + 3, 1'b1, 1'b0, 4'b0000);
        // Force in RUN with sleep permitted: never gates
        tick(100);
        chk("force_hold_cg_en", {3'b000, cg_if.cg_en_o}, 4'b0001);
        cg_if.force_en_i = 1'b0;
        s = edge_cnt + 1;
        push(s + 9, 1'b0, 1'b1, '0);
        tick(12);

        // Asynchronous reset while gated
        chk("pre_reset_cg_en", {3'b000, cg_if.cg_en_o}, 4'b0000);
        push(edge_cnt, 1'b1, 1'b0, 4'b0000);
        rst_n = 1'b0;
        #1;
        chk("async_reset_cg_en",    {3'b000, cg_if.cg_en_o},    4'b0001);
        chk("async_reset_sleeping", {3'b000, cg_if.sleeping_o}, 4'b0000);
        tick(2);
        rst_n = 1'b1;
        // Back in RUN with idle still present: full gating count
        s = edge_cnt + 1;
        push(s + 9, 1'b0, 1'b1, '0);
        tick(12);
        cg_if.sleep_en_i = 1'b0;
        s = edge_cnt + 1;
        push(s + 1, 1'b1, 1'b1, 4'b0000);
        push(s + 3, 1'b1, 1'b0, 4'b0000);
        tick(6);

        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event expected edge=%0d cg=%b sl=%b ack=%b, did not occur",
                     e.cyc, e.cg, e.sl, e.ack);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
